dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store path (port 0) and a secondary master such as a program loader or debug/DMA engine (port 1). It sits between the MemOrIO memory-side outputs and the data memory, issuing at most one memory access per cycle. Read data is routed back to the owning port one cycle later. Grants are round-robin with optional bounded bursts.

## Interface
Parameters:
- ADDR_W, 32, byte-address width presented to memory
- DATA_W, 32, data width
- MAX_BURST, 8, maximum consecutive locked grants to one port while the other port is requesting (1..255)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, port 0 (CPU) / port 1
- we0 / we1  in  1  1 = write, 0 = read; valid while req
- lock0 / lock1  in  1  request to keep the grant next cycle (burst)
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational grant; access is performed this cycle
- rvalid0 / rvalid1  out  1  registered; read data for that port valid this cycle
- rdata0 / rdata1  out  DATA_W  read data; equals mem_rdata, qualified by rvalid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after the address

## Operation
- State: last (port most recently granted, 1 bit), owner (locked port, 1 bit, plus owner_vld), burst_cnt (8 bits), rd_tag (2 bits: pending read for port 0 / port 1).
- Winner selection, in order:
  - owner_vld and req[owner]: the owner wins.
  - Only one port requests: that port wins.
  - Both request: the port other than last wins.
- Exactly one gnt is asserted when any req is high. Neither gnt is asserted when no req is high.
- Memory outputs are muxed from the winner. mem_we = gnt & we. With no grant, mem_we = 0, and mem_addr/mem_wdata hold port 0 values.
- Lock/burst:
  - On a granted cycle with lockN = 1, set owner = N and owner_vld = 1. Otherwise clear owner_vld.
  - burst_cnt increments on each granted cycle by the owner while the other port requests, and resets to 0 on an owner change or unlock.
  - When burst_cnt reaches MAX_BURST−1 and the other port is requesting, clear owner_vld at that edge. The other port wins next cycle regardless of lock (starvation bound).
- Owner drops req while owner_vld: owner_vld clears and arbitration is normal that cycle.
- last updates to the winner on every granted cycle.
- Read return:
  - rd_tag[N] <= gnt N & ~weN.
  - rvalidN = rd_tag[N].
  - rdataN = mem_rdata.
- Writes produce no rvalid. Back-to-back reads, interleaved between ports, are fully pipelined.
- Requesters must hold req/we/addr/wdata stable until gnt is seen. The CPU port must stall its pipeline when req0 & ~gnt0.

## Timing
- Reset values: last = 1 (port 0 wins the first contention), owner_vld = 0, burst_cnt = 0, rd_tag = 0. Hence rvalid0/1 = 0 in the cycle after reset.
- gnt0/gnt1 and mem_* are combinational and low during reset cycles. reset overrides req, so no grant and mem_we = 0.
- Grant latency is 0 cycles. Read data latency is 1 cycle after gnt.
- Throughput is one access per cycle. Under continuous contention with no lock, grants strictly alternate.
- Reset asserted the cycle after a read grant: rvalid is forced 0 and the read is dropped.
- Simultaneous lock from both ports: only the winner's lock takes effect.

## Structure
- Shared package: port index constants (PORT_CPU = 0, PORT_AUX = 1) and the default MAX_BURST.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin pick from (req, last, owner_vld, owner) returning the winner index and any_grant. All remaining logic (state registers, muxing, read tag pipeline) stays in dmem_arbiter.

## Test plan
- Reset, then req0 read at addr 0x10 with no other traffic → gnt0 = 1 same cycle, mem_addr = 0x10, mem_we = 0; next cycle rvalid0 = 1 with rdata0 = mem_rdata, rvalid1 = 0.
- Both ports request continuously without lock, starting right after reset → grant sequence 0,1,0,1,…; rvalid tags follow the grants one cycle later.
- Port 1 write burst with lock1 = 1 for 20 cycles, port 0 idle → gnt1 every cycle, mem_we = 1, no rvalid.
- Port 1 locked burst with req0 held high and MAX_BURST = 8 → exactly 8 consecutive gnt1, then gnt0 on the 9th cycle; port 1 regains the grant after that.
- Port 0 read granted in cycle n, port 1 read in cycle n+1 → rvalid0 in n+1 and rvalid1 in n+2 with the respective mem_rdata values; never both rvalid in the same cycle.
- reset asserted mid-burst, in the cycle after a read grant → no rvalid next cycle; once reset is released and both ports request, port 0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dmem_arbiter_pkg
// Description : Port indices and defaults shared by the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam logic c_PORT_CPU          = 1'b0;
    localparam logic c_PORT_AUX          = 1'b1;
    localparam int   c_DEFAULT_MAX_BURST = 8;
    localparam int   c_BURST_CNT_W       = 8;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : dmem_arbiter_if
// Description : Requester and memory-side signals of the two-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic              lock0;
    logic              lock1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_we, mem_addr, mem_wdata
    );

    // Requester / memory view
    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational 2-way round-robin pick with owner override.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_owner_vld,
    input  logic       i_owner,
    output logic       o_win,
    output logic       o_any_grant
);

    always_comb begin
        o_win       = c_PORT_CPU;
        o_any_grant = |i_req;
        if (i_owner_vld && i_req[i_owner]) begin
            o_win = i_owner;
        end else if (i_req == 2'b10) begin
            o_win = c_PORT_AUX;
        end else if (i_req == 2'b11) begin
            o_win = other_port(i_last);
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter sharing one data memory between two ports,
//               with bounded locked bursts and one-cycle read return.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = c_DEFAULT_MAX_BURST
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [c_BURST_CNT_W-1:0] c_BURST_LAST = c_BURST_CNT_W'(MAX_BURST - 1);

    logic                     r_last;
    logic                     r_owner;
    logic                     r_owner_vld;
    logic [c_BURST_CNT_W-1:0] r_burst_cnt;
    logic [1:0]               r_rd_tag;

    logic [1:0]               w_req;
    logic                     w_win;
    logic                     w_any;
    logic                     w_sel_aux;
    logic                     w_gnt0;
    logic                     w_gnt1;
    logic                     w_win_we;
    logic                     w_win_lock;
    logic                     w_other_req;
    logic [c_BURST_CNT_W-1:0] w_cnt_cur;
    logic [c_BURST_CNT_W-1:0] w_cnt_nxt;
    logic                     w_owner_nxt;
    logic                     w_owner_vld_nxt;
    logic [ADDR_W-1:0]        w_mem_addr;
    logic [DATA_W-1:0]        w_mem_wdata;

    // Reset masks requests so nothing reaches memory during reset cycles.
    assign w_req = {bus.req1, bus.req0} & {2{~reset}};

    rr_pick2 u_pick (
        .i_req       (w_req),
        .i_last      (r_last),
        .i_owner_vld (r_owner_vld),
        .i_owner     (r_owner),
        .o_win       (w_win),
        .o_any_grant (w_any)
    );

    assign w_sel_aux   = w_any & (w_win == c_PORT_AUX);
    assign w_gnt0      = w_any & (w_win == c_PORT_CPU);
    assign w_gnt1      = w_sel_aux;
    assign w_win_we    = w_sel_aux ? bus.we1   : bus.we0;
    assign w_win_lock  = w_sel_aux ? bus.lock1 : bus.lock0;
    assign w_other_req = w_req[other_port(w_win)];
    assign w_mem_addr  = w_sel_aux ? bus.addr1  : bus.addr0;
    assign w_mem_wdata = w_sel_aux ? bus.wdata1 : bus.wdata0;

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.mem_we    = w_any & w_win_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    // Read tags are masked by reset so an in-flight read is dropped.
    assign bus.rvalid0 = r_rd_tag[0] & ~reset;
    assign bus.rvalid1 = r_rd_tag[1] & ~reset;
    assign bus.rdata0  = bus.mem_rdata;
    assign bus.rdata1  = bus.mem_rdata;

    // The burst count only carries over while the same port keeps ownership.
    // Hitting the limit with the other port waiting forces a release.
    always_comb begin
        w_cnt_cur       = (r_owner_vld && (r_owner == w_win)) ? r_burst_cnt : '0;
        w_cnt_nxt       = '0;
        w_owner_nxt     = r_owner;
        w_owner_vld_nxt = 1'b0;
        if (w_any && w_win_lock) begin
            if (!(w_other_req && (w_cnt_cur == c_BURST_LAST))) begin
                w_owner_vld_nxt = 1'b1;
                w_owner_nxt     = w_win;
                w_cnt_nxt       = w_other_req ? (w_cnt_cur + 1'b1) : w_cnt_cur;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last      <= c_PORT_AUX;
            r_owner     <= c_PORT_CPU;
            r_owner_vld <= 1'b0;
            r_burst_cnt <= '0;
            r_rd_tag    <= 2'b00;
        end else begin
            if (w_any) begin
                r_last <= w_win;
            end
            r_owner     <= w_owner_nxt;
            r_owner_vld <= w_owner_vld_nxt;
            r_burst_cnt <= w_cnt_nxt;
            r_rd_tag    <= {w_gnt1 & ~bus.we1, w_gnt0 & ~bus.we0};
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int c_ADDR_W    = 32;
    localparam int c_DATA_W    = 32;
    localparam int c_MAX_BURST = 8;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    dmem_arbiter_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W    (c_ADDR_W),
        .DATA_W    (c_DATA_W),
        .MAX_BURST (c_MAX_BURST)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.we0   = 1'b0;
        bus.we1   = 1'b0;
        bus.lock0 = 1'b0;
        bus.lock1 = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        idle();
        bus.addr0     = '0;
        bus.addr1     = '0;
        bus.wdata0    = '0;
        bus.wdata1    = '0;
        bus.mem_rdata = '0;
        tick();
        tick();

        // Requests during reset are ignored
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b1; bus.we1 = 1'b1;
        settle();
        chk1("rst_gnt0",   bus.gnt0,    1'b0);
        chk1("rst_gnt1",   bus.gnt1,    1'b0);
        chk1("rst_mem_we", bus.mem_we,  1'b0);
        chk1("rst_rvalid0", bus.rvalid0, 1'b0);

        tick(); reset = 1'b0; idle(); settle();
        chk1("post_rst_rvalid0", bus.rvalid0, 1'b0);
        chk1("post_rst_rvalid1", bus.rvalid1, 1'b0);

        // Single port-0 read
        tick(); bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10; settle();
        chk1("rd0_gnt0",     bus.gnt0,     1'b1);
        chk1("rd0_gnt1",     bus.gnt1,     1'b0);
        chkw("rd0_mem_addr", bus.mem_addr, 32'h10);
        chk1("rd0_mem_we",   bus.mem_we,   1'b0);
        tick(); idle(); bus.mem_rdata = 32'hCAFE_0010; settle();
        chk1("rd0_rvalid0", bus.rvalid0, 1'b1);
        chkw("rd0_rdata0",  bus.rdata0,  32'hCAFE_0010);
        chk1("rd0_rvalid1", bus.rvalid1, 1'b0);
        chk1("rd0_idle_gnt0", bus.gnt0,  1'b0);

        // Continuous contention straight after reset: strict alternation from port 0
        tick(); reset = 1'b1; settle();
        tick(); reset = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 32'h100; bus.addr1 = 32'h200;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            bus.mem_rdata = 32'hD000_0000 + 32'(k);
            settle();
            chk1("alt_gnt0", bus.gnt0, (k % 2) == 0);
            chk1("alt_gnt1", bus.gnt1, (k % 2) == 1);
            chkw("alt_mem_addr", bus.mem_addr, ((k % 2) == 0) ? 32'h100 : 32'h200);
            chk1("alt_rvalid0", bus.rvalid0, (k > 0) && ((k % 2) == 1));
            chk1("alt_rvalid1", bus.rvalid1, (k > 0) && ((k % 2) == 0));
            if ((k % 2) == 1) chkw("alt_rdata0", bus.rdata0, 32'hD000_0000 + 32'(k));
        end
        tick(); idle(); settle();
        chk1("alt_tail_rvalid1", bus.rvalid1, 1'b1);
        chk1("alt_tail_rvalid0", bus.rvalid0, 1'b0);
        chk1("nogrant_gnt1",     bus.gnt1,    1'b0);
        chk1("nogrant_mem_we",   bus.mem_we,  1'b0);
        chkw("nogrant_mem_addr", bus.mem_addr, 32'h100);

        // Locked port-1 write burst, port 0 idle
        for (int k = 0; k < 20; k++) begin
            tick();
            bus.req1 = 1'b1; bus.we1 = 1'b1; bus.lock1 = 1'b1;
            bus.addr1  = 32'h300 + 32'(4 * k);
            bus.wdata1 = 32'hA5A5_0000 + 32'(k);
            settle();
            chk1("wburst_gnt1",   bus.gnt1,   1'b1);
            chk1("wburst_mem_we", bus.mem_we, 1'b1);
            chkw("wburst_wdata",  bus.mem_wdata, 32'hA5A5_0000 + 32'(k));
            chk1("wburst_rvalid", bus.rvalid0 | bus.rvalid1, 1'b0);
        end

        // Port 0 now waits: 8 more locked grants to port 1, then port 0, then port 1
        for (int c = 0; c < 10; c++) begin
            tick();
            bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = 32'h500;
            bus.mem_rdata = 32'hB000_0000 + 32'(c);
            settle();
            chk1("bound_gnt1",    bus.gnt1,    c != 8);
            chk1("bound_gnt0",    bus.gnt0,    c == 8);
            chk1("bound_rvalid0", bus.rvalid0, c == 9);
            if (c == 9) chkw("bound_rdata0", bus.rdata0, 32'hB000_0009);
        end

        // Interleaved reads: port 0 then port 1
        tick(); idle(); settle();
        chk1("gap_rvalid", bus.rvalid0 | bus.rvalid1, 1'b0);
        tick(); bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h40; settle();
        chk1("il_gnt0",     bus.gnt0,     1'b1);
        chkw("il_addr0",    bus.mem_addr, 32'h40);
        tick(); bus.req0 = 1'b0; bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h80;
        bus.mem_rdata = 32'h1111_1111; settle();
        chk1("il_gnt1",     bus.gnt1,     1'b1);
        chkw("il_addr1",    bus.mem_addr, 32'h80);
        chk1("il_rvalid0",  bus.rvalid0,  1'b1);
        chkw("il_rdata0",   bus.rdata0,   32'h1111_1111);
        chk1("il_n1_rvalid1", bus.rvalid1, 1'b0);
        tick(); idle(); bus.mem_rdata = 32'h2222_2222; settle();
        chk1("il_rvalid1",  bus.rvalid1,  1'b1);
        chkw("il_rdata1",   bus.rdata1,   32'h2222_2222);
        chk1("il_n2_rvalid0", bus.rvalid0, 1'b0);

        // Reset in the cycle after a read grant during a locked read burst
        tick(); bus.req1 = 1'b1; bus.we1 = 1'b0; bus.lock1 = 1'b1; bus.addr1 = 32'h600; settle();
        chk1("rb_gnt1_a", bus.gnt1, 1'b1);
        tick(); settle();
        chk1("rb_gnt1_b",   bus.gnt1,    1'b1);
        chk1("rb_rvalid1",  bus.rvalid1, 1'b1);
        tick(); reset = 1'b1; settle();
        chk1("rb_rst_rvalid1", bus.rvalid1, 1'b0);
        chk1("rb_rst_gnt1",    bus.gnt1,    1'b0);
        chk1("rb_rst_mem_we",  bus.mem_we,  1'b0);
        tick(); reset = 1'b0; bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h700; settle();
        chk1("rb_post_rvalid1", bus.rvalid1, 1'b0);
        chk1("rb_post_rvalid0", bus.rvalid0, 1'b0);
        chk1("rb_post_gnt0",    bus.gnt0,    1'b1);
        chk1("rb_post_gnt1",    bus.gnt1,    1'b0);

        tick(); idle(); settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
